// File: rtl/curl_avalon_arbiter_if.sv
// One Avalon-MM burst-capable port of the Curl calculation unit.
//
// Signals:
//   Command, driven by the bus master:
//     address, byteenable, read, write, writedata, burstcount,
//     chipselect, beginbursttransfer
//   Response, driven by the bus slave:
//     waitrequest, readdatavalid, readdata
//
// Modports:
//   master - the side that issues commands.
//   slave  - the side that accepts commands and returns read data.
interface curl_avalon_arbiter_if #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 1024,
  parameter int BURST_W = 11
);
  localparam int BE_W = DATA_W / 8;

  logic [ADDR_W-1:0]  address;
  logic [BE_W-1:0]    byteenable;
  logic               read;
  logic               write;
  logic [DATA_W-1:0]  writedata;
  logic [BURST_W-1:0] burstcount;
  logic               chipselect;
  logic               beginbursttransfer;
  logic               waitrequest;
  logic               readdatavalid;
  logic [DATA_W-1:0]  readdata;

  modport master (
    output address, byteenable, read, write, writedata, burstcount,
           chipselect, beginbursttransfer,
    input  waitrequest, readdatavalid, readdata
  );

  modport slave (
    input  address, byteenable, read, write, writedata, burstcount,
           chipselect, beginbursttransfer,
    output waitrequest, readdatavalid, readdata
  );
endinterface

// File: rtl/curl_avalon_arbiter.sv
// Two-master round-robin arbiter in front of one Avalon-MM burst slave.
//
// Ports:
//   clk      in   rising-edge clock
//   reset_n  in   asynchronous, active-low reset
//   m0, m1   slave modports: the two competing masters
//   s        master modport: the shared curl_avalon slave
//   rsp_err  out  sticky flag: read data arrived with no read outstanding
//
// The grant is held for a whole write burst. Every accepted read burst is
// logged as {owner, beat count} in a small in-order queue, so each
// readdatavalid beat can be steered back to the master that issued it.
module curl_avalon_arbiter #(
  parameter int BURST_W  = 11,
  parameter int MAX_PEND = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  curl_avalon_arbiter_if.slave  m0,
  curl_avalon_arbiter_if.slave  m1,
  curl_avalon_arbiter_if.master s,
  output logic                  rsp_err
);
  localparam int PTR_W = $clog2(MAX_PEND);
  localparam logic [PTR_W:0] PEND_FULL = (PTR_W + 1)'(MAX_PEND);

  typedef enum logic [1:0] {IDLE = 2'd0, CMD = 2'd1, WBURST = 2'd2} state_e;

  state_e             state_q, state_d;
  logic               gnt_q, gnt_d;
  logic               last_q, last_d;
  logic               first_q, first_d;
  logic               rsp_err_q, rsp_err_d;
  logic [BURST_W-1:0] wbeats_q, wbeats_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]     count_q, count_d;
  logic               own_q [MAX_PEND];
  logic               own_d [MAX_PEND];
  logic [BURST_W-1:0] cnt_q [MAX_PEND];
  logic [BURST_W-1:0] cnt_d [MAX_PEND];

  logic               req0, req1, g_read, g_write;
  logic [BURST_W-1:0] g_burst, head_cnt;
  logic               head_own, full, empty, s_accept, push, pop, rvalid;
  logic               rd_str, wr_str, bbt, g_wait;

  assign req0     = m0.read | m0.write;
  assign req1     = m1.read | m1.write;
  assign g_read   = gnt_q ? m1.read : m0.read;
  assign g_write  = gnt_q ? m1.write : m0.write;
  assign g_burst  = gnt_q ? m1.burstcount : m0.burstcount;
  assign full     = (count_q == PEND_FULL);
  assign empty    = (count_q == '0);
  assign s_accept = ~s.waitrequest;
  assign head_own = own_q[rd_ptr_q];
  assign head_cnt = cnt_q[rd_ptr_q];
  assign push     = rd_str & s_accept;
  assign rvalid   = s.readdatavalid & ~empty;
  assign pop      = rvalid & (head_cnt == BURST_W'(1));

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      gnt_q     <= 1'b0;
      last_q    <= 1'b1;
      first_q   <= 1'b0;
      wbeats_q  <= '0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      last_q    <= last_d;
      first_q   <= first_d;
      wbeats_q  <= wbeats_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      rsp_err_q <= rsp_err_d;
    end
  end

  // Queue payload is only meaningful below count_q, so it needs no reset.
  always_ff @(posedge clk) begin
    own_q <= own_d;
    cnt_q <= cnt_d;
  end

  // Next-state logic.
  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    last_d   = last_q;
    first_d  = 1'b0;
    wbeats_d = wbeats_q;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          // On a tie the master that did not win last time goes next.
          gnt_d   = (req0 && req1) ? ~last_q : req1;
          last_d  = gnt_d;
          first_d = 1'b1;
          state_d = CMD;
        end
      end
      CMD: begin
        // Burst start is flagged on the first cycle the command is actually
        // presented; a read held back by a full queue presents nothing yet.
        first_d = first_q & ~(rd_str | wr_str);
        if (!g_read && !g_write) begin
          state_d = IDLE;
        end else if (rd_str && s_accept) begin
          state_d = IDLE;
        end else if (wr_str && s_accept) begin
          if (g_burst > BURST_W'(1)) begin
            wbeats_d = g_burst - BURST_W'(1);
            state_d  = WBURST;
          end else begin
            state_d = IDLE;
          end
        end
      end
      WBURST: begin
        // No timeout: a master that pauses its burst keeps the grant.
        if (wr_str && s_accept) begin
          wbeats_d = wbeats_q - BURST_W'(1);
          if (wbeats_q == BURST_W'(1)) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic.
  always_comb begin
    rd_str = 1'b0;
    wr_str = 1'b0;
    bbt    = 1'b0;
    g_wait = 1'b1;
    case (state_q)
      CMD: begin
        rd_str = g_read & ~full;
        wr_str = g_write & ~g_read;
        g_wait = (g_read && full) ? 1'b1 : s.waitrequest;
        bbt    = first_q & (rd_str | wr_str);
      end
      WBURST: begin
        wr_str = g_write;
        g_wait = s.waitrequest;
      end
      default: ;
    endcase
  end

  // Pending read queue and response routing.
  always_comb begin
    own_d    = own_q;
    cnt_d    = cnt_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    // Push is blocked while full and decrement needs a non-empty queue, so
    // the written slot and the head slot never coincide.
    if (rvalid) cnt_d[rd_ptr_q] = head_cnt - BURST_W'(1);
    if (push) begin
      own_d[wr_ptr_q] = gnt_q;
      cnt_d[wr_ptr_q] = g_burst;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    count_d   = count_q + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
    rsp_err_d = rsp_err_q | (s.readdatavalid & empty);
  end

  assign s.address            = gnt_q ? m1.address : m0.address;
  assign s.byteenable         = gnt_q ? m1.byteenable : m0.byteenable;
  assign s.writedata          = gnt_q ? m1.writedata : m0.writedata;
  assign s.burstcount         = g_burst;
  assign s.read               = rd_str;
  assign s.write              = wr_str;
  assign s.chipselect         = rd_str | wr_str;
  assign s.beginbursttransfer = bbt;

  assign m0.waitrequest   = gnt_q ? 1'b1 : g_wait;
  assign m1.waitrequest   = gnt_q ? g_wait : 1'b1;
  assign m0.readdatavalid = rvalid & ~head_own;
  assign m1.readdatavalid = rvalid & head_own;
  assign m0.readdata      = s.readdata;
  assign m1.readdata      = s.readdata;
  assign rsp_err          = rsp_err_q;

  // Masters have no chipselect/beginbursttransfer of their own.
  logic unused_ok;
  assign unused_ok = &{1'b0, m0.chipselect, m0.beginbursttransfer,
                       m1.chipselect, m1.beginbursttransfer};
endmodule

// File: tb/tb_curl_avalon_arbiter.sv
module tb_curl_avalon_arbiter;
  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 1024;
  localparam int BURST_W  = 11;
  localparam int MAX_PEND = 4;

  typedef struct packed {
    logic               wr;
    logic [ADDR_W-1:0]  addr;
    logic [BURST_W-1:0] burst;
    logic [31:0]        dtag;
  } cmd_t;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              rsp_err;
  logic              s_wait_base = 1'b0;
  logic              wr_toggle = 1'b0;
  logic              tog = 1'b0;
  logic              s_rdv = 1'b0;
  logic [DATA_W-1:0] s_rdata = '0;

  cmd_t       cmd_q[$];
  logic [1:0] rd_q[$];
  int         n_tests = 0;
  int         n_fail = 0;

  curl_avalon_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_W(BURST_W)) m0_if ();
  curl_avalon_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_W(BURST_W)) m1_if ();
  curl_avalon_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_W(BURST_W)) s_if ();

  curl_avalon_arbiter #(.BURST_W(BURST_W), .MAX_PEND(MAX_PEND)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .m0     (m0_if),
    .m1     (m1_if),
    .s      (s_if),
    .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) tog <= ~tog;

  assign s_if.waitrequest          = s_wait_base | (wr_toggle & tog);
  assign s_if.readdatavalid        = s_rdv;
  assign s_if.readdata             = s_rdata;
  assign m0_if.chipselect          = 1'b0;
  assign m0_if.beginbursttransfer  = 1'b0;
  assign m1_if.chipselect          = 1'b0;
  assign m1_if.beginbursttransfer  = 1'b0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Expected slave-side beats: one record per write beat, one per read.
  function automatic void push_cmd(input logic wr, input logic [ADDR_W-1:0] a, input int burst);
    cmd_t c;
    for (int i = 0; i < (wr ? burst : 1); i++) begin
      c.wr    = wr;
      c.addr  = a;
      c.burst = BURST_W'(burst);
      c.dtag  = wr ? (a + 32'(i)) : 32'h0;
      cmd_q.push_back(c);
    end
  endfunction

  task automatic drive_m(input int m, input logic rd, input logic wr, input logic [ADDR_W-1:0] a,
                         input int bc, input logic [31:0] tag);
    if (m == 0) begin
      m0_if.read = rd; m0_if.write = wr; m0_if.address = a;
      m0_if.burstcount = BURST_W'(bc); m0_if.writedata = DATA_W'(tag);
    end else begin
      m1_if.read = rd; m1_if.write = wr; m1_if.address = a;
      m1_if.burstcount = BURST_W'(bc); m1_if.writedata = DATA_W'(tag);
    end
  endtask

  // Avalon master: hold the command, advance a beat whenever waitrequest is low.
  task automatic mst_cmd(input int m, input logic wr, input logic [ADDR_W-1:0] a, input int burst);
    int   beat = 0;
    int   guard = 0;
    int   nb = wr ? burst : 1;
    logic acc;
    drive_m(m, ~wr, wr, a, burst, a);
    while (beat < nb) begin
      @(negedge clk);
      acc = (m == 0) ? ~m0_if.waitrequest : ~m1_if.waitrequest;
      @(posedge clk); #1;
      if (acc) begin
        beat++;
        if (beat < nb) drive_m(m, ~wr, wr, a, burst, a + 32'(beat));
      end
      guard++;
      if (guard > 300) begin
        check($sformatf("m%0d_cmd_timeout", m), 128'(beat), 128'(nb));
        break;
      end
    end
    drive_m(m, 1'b0, 1'b0, a, burst, 32'h0);
  endtask

  task automatic ret_beats(input int n);
    for (int i = 0; i < n; i++) begin
      s_rdv = 1'b1;
      s_rdata = DATA_W'(32'hD000 + 32'(i));
      @(posedge clk); #1;
    end
    s_rdv = 1'b0;
  endtask

  // Slave-side command monitor.
  int   beat_idx = 0;
  logic presented = 1'b0;
  always @(negedge clk) begin
    cmd_t e;
    if (!reset_n) begin
      beat_idx = 0;
      presented = 1'b0;
    end else if (s_if.read || s_if.write) begin
      check("bbt", s_if.beginbursttransfer, (beat_idx == 0) && !presented);
      check("chipselect", s_if.chipselect, 1'b1);
      presented = 1'b1;
      if (!s_if.waitrequest) begin
        if (cmd_q.size() == 0) begin
          check("cmd_unexpected", s_if.address, 128'hFFFF_FFFF_FFFF);
        end else begin
          e = cmd_q.pop_front();
          check("cmd_wr", s_if.write, e.wr);
          check("cmd_addr", s_if.address, e.addr);
          check("cmd_burst", s_if.burstcount, e.burst);
          if (e.wr) check("cmd_wdata", s_if.writedata[31:0], e.dtag);
          beat_idx++;
          if (!e.wr || beat_idx == int'(e.burst)) begin
            beat_idx = 0;
            presented = 1'b0;
          end
        end
      end
    end
  end

  // Read-return monitor.
  always @(negedge clk) begin
    logic [1:0] e;
    if (reset_n && s_rdv) begin
      e = (rd_q.size() != 0) ? rd_q.pop_front() : 2'b00;
      check("rdv_route", {m1_if.readdatavalid, m0_if.readdatavalid}, e);
      check("rdata_m0", m0_if.readdata[31:0], s_rdata[31:0]);
      check("rdata_m1", m1_if.readdata[31:0], s_rdata[31:0]);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, tests %0d failed %0d", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    m0_if.byteenable = '1;
    m1_if.byteenable = '1;
    drive_m(0, 1'b0, 1'b0, '0, 1, 32'h0);
    drive_m(1, 1'b0, 1'b0, '0, 1, 32'h0);
    repeat (2) @(posedge clk); #1;
    check("rst_sread", s_if.read, 1'b0);
    check("rst_swrite", s_if.write, 1'b0);
    check("rst_cs", s_if.chipselect, 1'b0);
    check("rst_bbt", s_if.beginbursttransfer, 1'b0);
    check("rst_m0_wait", m0_if.waitrequest, 1'b1);
    check("rst_m1_wait", m1_if.waitrequest, 1'b1);
    check("rst_rdv", {m1_if.readdatavalid, m0_if.readdatavalid}, 2'b00);
    check("rst_err", rsp_err, 1'b0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Tie from reset: m0, m1, m0, m1.
    push_cmd(1'b0, 32'h100, 1); push_cmd(1'b0, 32'h200, 1);
    push_cmd(1'b0, 32'h104, 1); push_cmd(1'b0, 32'h204, 1);
    rd_q.push_back(2'b01); rd_q.push_back(2'b10);
    rd_q.push_back(2'b01); rd_q.push_back(2'b10);
    fork
      begin mst_cmd(0, 1'b0, 32'h100, 1); mst_cmd(0, 1'b0, 32'h104, 1); end
      begin mst_cmd(1, 1'b0, 32'h200, 1); mst_cmd(1, 1'b0, 32'h204, 1); end
    join
    ret_beats(4);

    // Write burst lock with a stuttering slave; m1 waits for all 4 beats.
    push_cmd(1'b1, 32'h300, 4);
    push_cmd(1'b0, 32'h400, 1);
    rd_q.push_back(2'b10);
    wr_toggle = 1'b1;
    fork
      mst_cmd(0, 1'b1, 32'h300, 4);
      begin @(posedge clk); #1; mst_cmd(1, 1'b0, 32'h400, 1); end
    join
    wr_toggle = 1'b0;
    ret_beats(1);

    // Read routing: 3 beats to m0, then 2 beats to m1.
    push_cmd(1'b0, 32'h500, 3); push_cmd(1'b0, 32'h600, 2);
    repeat (3) rd_q.push_back(2'b01);
    repeat (2) rd_q.push_back(2'b10);
    mst_cmd(0, 1'b0, 32'h500, 3);
    mst_cmd(1, 1'b0, 32'h600, 2);
    ret_beats(5);

    // Queue full: four reads outstanding, the fifth waits for one return.
    for (int i = 0; i < 5; i++) begin
      push_cmd(1'b0, 32'h700 + 32'(4 * i), 1);
      rd_q.push_back(2'b01);
    end
    fork
      mst_cmd(0, 1'b0, 32'h700, 1);
      begin
        @(negedge clk); check("lat_idle_sread", s_if.read, 1'b0);
        @(negedge clk); check("lat_cmd_sread", s_if.read, 1'b1);
      end
    join
    for (int i = 1; i < 4; i++) mst_cmd(0, 1'b0, 32'h700 + 32'(4 * i), 1);
    fork
      mst_cmd(0, 1'b0, 32'h710, 1);
      begin
        repeat (3) @(negedge clk);
        check("full_sread", s_if.read, 1'b0);
        check("full_m0_wait", m0_if.waitrequest, 1'b1);
        @(posedge clk); #1;
        s_rdv = 1'b1; s_rdata = DATA_W'(32'hE000);
        @(negedge clk); check("full_sread_rdv", s_if.read, 1'b0);
        @(posedge clk); #1;
        s_rdv = 1'b0;
        @(negedge clk);
        check("freed_sread", s_if.read, 1'b1);
        check("freed_m0_wait", m0_if.waitrequest, 1'b0);
      end
    join
    ret_beats(4);

    // Stray read data with nothing outstanding.
    s_rdv = 1'b1; s_rdata = DATA_W'(32'hBAD0);
    @(posedge clk); #1;
    s_rdv = 1'b0;
    repeat (3) @(posedge clk); #1;
    check("err_set", rsp_err, 1'b1);

    // Reset during an m1 write burst with 2 beats left.
    push_cmd(1'b1, 32'h800, 2);
    cmd_q[cmd_q.size()-1].burst = BURST_W'(4);
    cmd_q[cmd_q.size()-2].burst = BURST_W'(4);
    drive_m(1, 1'b0, 1'b1, 32'h800, 4, 32'h800);
    @(posedge clk); #1;
    @(posedge clk); #1;
    drive_m(1, 1'b0, 1'b1, 32'h800, 4, 32'h801);
    @(posedge clk); #1;
    drive_m(1, 1'b0, 1'b1, 32'h800, 4, 32'h802);
    #2;
    check("pre_rst_swrite", s_if.write, 1'b1);
    check("err_held", rsp_err, 1'b1);
    reset_n = 1'b0;
    #1;
    check("arst_swrite", s_if.write, 1'b0);
    check("arst_cs", s_if.chipselect, 1'b0);
    check("arst_bbt", s_if.beginbursttransfer, 1'b0);
    check("arst_m0_wait", m0_if.waitrequest, 1'b1);
    check("arst_m1_wait", m1_if.waitrequest, 1'b1);
    check("arst_rdv", {m1_if.readdatavalid, m0_if.readdatavalid}, 2'b00);
    check("arst_err", rsp_err, 1'b0);
    drive_m(1, 1'b0, 1'b0, 32'h0, 1, 32'h0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // After reset the tie goes to m0 again.
    push_cmd(1'b0, 32'h900, 1); push_cmd(1'b0, 32'hA00, 1);
    rd_q.push_back(2'b01); rd_q.push_back(2'b10);
    fork
      mst_cmd(0, 1'b0, 32'h900, 1);
      mst_cmd(1, 1'b0, 32'hA00, 1);
    join
    ret_beats(2);
    check("post_rst_err_clear", rsp_err, 1'b0);
    check("cmd_q_drained", 128'(cmd_q.size()), 128'd0);
    check("rd_q_drained", 128'(rd_q.size()), 128'd0);

    // A stray beat after reset raises the flag again.
    s_rdv = 1'b1; s_rdata = DATA_W'(32'hBAD1);
    @(posedge clk); #1;
    s_rdv = 1'b0;
    @(posedge clk); #1;
    check("err_stray_after_rst", rsp_err, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/curl_avalon_arbiter.md
# curl_avalon_arbiter

Two-master round-robin arbiter that shares one Avalon-MM burst-capable slave port of the Curl calculation unit, for example between the host CSR/DMA path and the internal nonce-search sequencer. It locks the grant for the whole write burst. It tracks outstanding read bursts in an ordered pending queue so that each `readdatavalid` beat is returned to the master that issued the read. It sits between the two masters and the `curl_avalon` slave, and presents the same signal set as that slave: 1024-bit data, 11-bit burstcount, `waitrequest`, `readdatavalid`.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 1024, data width; `BE_W = DATA_W/8`
- `BURST_W`, 11, burstcount width (max burst 1024)
- `MAX_PEND`, 4, pending read-burst queue depth (power of 2, ≥2)

Ports:
- `clk`  in  1  clock, all logic on rising edge
- `reset_n`  in  1  reset, **asynchronous, active-low**
- `m{0,1}_address`  in  ADDR_W  master command address
- `m{0,1}_byteenable`  in  BE_W  write byte enables
- `m{0,1}_read`, `m{0,1}_write`  in  1  command strobes (mutually exclusive per master)
- `m{0,1}_writedata`  in  DATA_W  write beat data
- `m{0,1}_burstcount`  in  BURST_W  burst length, 1..2^(BURST_W-1)
- `m{0,1}_waitrequest`  out  1  stall to master
- `m{0,1}_readdatavalid`  out  1  read beat valid for this master
- `m{0,1}_readdata`  out  DATA_W  `s_readdata` broadcast to both masters
- `s_address`, `s_byteenable`, `s_writedata`, `s_burstcount`  out  matching widths  command to slave
- `s_chipselect`, `s_read`, `s_write`, `s_beginbursttransfer`  out  1  slave strobes
- `s_readdata`  in  DATA_W; `s_waitrequest`, `s_readdatavalid`  in  1
- `rsp_err`  out  1  sticky: `s_readdatavalid` arrived while the queue was empty

## Operation
- FSM states:
  - `IDLE`: no grant.
  - `CMD`: the granted master's first or only command cycle.
  - `WBURST`: remaining beats of a write burst.
- **IDLE**
  - Any `mN_read|mN_write` registers the grant and moves to `CMD`.
  - Both requesting: grant goes to the master not in `last_grant`.
  - `last_grant` resets to 1, so m0 wins the first tie.
  - `last_grant` updates on every grant.
- **Slave command mux**
  - In `CMD`/`WBURST`, the slave command equals the granted master's signals.
  - `s_chipselect = s_read | s_write`.
  - The ungranted master sees `waitrequest = 1`.
  - The granted master sees `waitrequest = s_waitrequest`, or 1 when its read is blocked.
- **Read in `CMD`**
  - If the queue is full (registered `full`), `s_read` is forced to 0 and the master is stalled.
  - Otherwise `s_read = 1`.
  - On `s_read && !s_waitrequest`: push {owner, burstcount} and return to `IDLE`.
- **Write in `CMD`**
  - On `s_write && !s_waitrequest`:
    - burstcount = 1: go to `IDLE`.
    - burstcount > 1: load `wbeats = burstcount-1` and go to `WBURST`.
- **WBURST**
  - Each accepted beat decrements `wbeats`.
  - When the beat accepted with `wbeats == 1` completes, go to `IDLE`.
  - The grant is never released mid-burst.
  - If the master deasserts `write` mid-burst, the arbiter waits (no timeout).
- `s_beginbursttransfer` is 1 only on the first cycle in `CMD`.
- **Read return**
  - Head entry has owner `h_own` and beat counter `h_cnt`, loaded from `burstcount`.
  - `mN_readdatavalid = s_readdatavalid && !empty && h_own == N`.
  - Each valid beat decrements `h_cnt`; the beat at `h_cnt == 1` pops the head.
  - Push and pop in the same cycle are allowed; occupancy is unchanged.
  - Pointers wrap modulo `MAX_PEND`.
- `s_readdatavalid` with the queue empty: beat is dropped, and `rsp_err` is set until reset.

## Timing
- Reset values:
  - FSM = `IDLE`, queue empty, `last_grant = 1`.
  - `s_read`/`s_write`/`s_chipselect`/`s_beginbursttransfer` = 0.
  - `m0/m1_waitrequest` = 1, `readdatavalid` = 0, `rsp_err` = 0.
  - The data/address buses are don't-care.
- Arbitration latency: request seen in `IDLE` at edge n; slave strobe is asserted in cycle n+1.
- Every command is followed by one `IDLE` cycle, so peak throughput is one command per 2 cycles plus waitrequest stalls.
- Read return has zero added latency: `mN_readdatavalid` is combinational from `s_readdatavalid`.
- Reset asserted mid-burst or with reads pending: immediate clear of all state. Later stray `readdatavalid` beats set `rsp_err`.
- A request arriving in the same cycle as the prior command's acceptance is arbitrated from the following `IDLE`.

## Test plan
- **Tie:** m0 and m1 both read (burst 1) from reset. Required: m0 granted first, m1 second, then m0 again if both still request; strobes alternate with one idle gap.
- **Write burst lock:** m0 writes burstcount 4, `s_waitrequest` toggling 1/0, while m1 requests.
  - 4 accepted beats reach the slave with `s_beginbursttransfer` on beat 1 only.
  - m1 is not granted until after the 4th beat.
- **Read routing:** m0 read burst 3, then m1 read burst 2. Slave returns 5 beats. Required: first 3 beats raise only `m0_readdatavalid`, last 2 only `m1_readdatavalid`.
- **Queue full:** MAX_PEND=4 outstanding reads with no return.
  - A 5th read keeps `s_read=0` and `waitrequest=1`.
  - One returned single beat frees a slot; `s_read` asserts the next `CMD` cycle.
- **Error:** `s_readdatavalid=1` with the queue empty. Required: no master `readdatavalid`, `rsp_err=1`, held until `reset_n` low.
- **Reset mid-burst:** `reset_n` low during m1 `WBURST` with 2 beats left. Required: all outputs at reset values asynchronously, and the next grant after release goes to m0.
